// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin sharing of one UART transmitter between
// NUM_REQ byte producers, with packet lock, lock timeout and busy watchdog.
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 1024,
  parameter int BUSY_WAIT    = 3,
  localparam int IW = $clog2(NUM_REQ),
  localparam int TW = $clog2(LOCK_TIMEOUT + 1),
  localparam int WW = $clog2(BUSY_WAIT + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [IW-1:0]        grant_id,
  output logic                 locked,
  output logic                 err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_WAIT_HI,
    S_WAIT_LO
  } state_t;

  state_t             state;
  logic [IW-1:0]      rr_ptr;
  logic               last_q;
  logic [WW-1:0]      wait_cnt;
  logic [TW-1:0]      idle_cnt;

  logic [IW-1:0]      win;
  logic               win_ok;
  logic [NUM_REQ-1:0] win_oh;
  logic [7:0]         win_data;
  logic               do_grant;
  logic               busy_to;
  logic               byte_done;
  logic               lock_idle;
  logic               lock_to;

  function automatic logic [IW-1:0] nxt(input logic [IW-1:0] x);
    return (x == IW'(NUM_REQ - 1)) ? '0 : x + IW'(1);
  endfunction

  function automatic logic [IW-1:0] wrap_add(
    input logic [IW-1:0] b,
    input int            k
  );
    int s;
    s = int'(b) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IW'(s);
  endfunction

  // Scan downward so the smallest offset from rr_ptr wins.
  always_comb begin
    win    = grant_id;
    win_ok = 1'b0;
    if (locked) begin
      win_ok = req_valid[grant_id];
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        if (req_valid[wrap_add(rr_ptr, k)]) begin
          win    = wrap_add(rr_ptr, k);
          win_ok = 1'b1;
        end
      end
    end
  end

  assign win_oh   = NUM_REQ'(1) << win;
  assign win_data = req_data[{win, 3'b000} +: 8];
  assign do_grant = (state == S_IDLE) && !tx_busy && win_ok;

  assign busy_to = (state == S_WAIT_HI) && !tx_busy &&
                   (wait_cnt == WW'(BUSY_WAIT - 1));
  assign byte_done = busy_to ||
                     ((state == S_WAIT_LO) && !tx_busy);

  assign lock_idle = (state == S_IDLE) && locked &&
                     !req_valid[grant_id];
  assign lock_to = lock_idle &&
                   (idle_cnt == TW'(LOCK_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      rr_ptr    <= '0;
      last_q    <= 1'b0;
      wait_cnt  <= '0;
      idle_cnt  <= '0;
      req_ready <= '0;
      tx_start  <= 1'b0;
      tx_data   <= '0;
      grant_id  <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
    end else begin
      tx_start  <= 1'b0;
      req_ready <= '0;
      unique case (state)
        S_IDLE: begin
          if (do_grant) begin
            tx_data   <= win_data;
            grant_id  <= win;
            tx_start  <= 1'b1;
            req_ready <= win_oh;
            last_q    <= req_last[win];
            locked    <= 1'b1;
            idle_cnt  <= '0;
            state     <= S_START;
          end else if (lock_to) begin
            locked   <= 1'b0;
            rr_ptr   <= nxt(grant_id);
            idle_cnt <= '0;
          end else if (lock_idle) begin
            idle_cnt <= idle_cnt + TW'(1);
          end
        end
        S_START: begin
          wait_cnt <= '0;
          state    <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (tx_busy) begin
            state <= S_WAIT_LO;
          end else if (!busy_to) begin
            wait_cnt <= wait_cnt + WW'(1);
          end
        end
        S_WAIT_LO: begin
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
      if (busy_to) begin
        err <= 1'b1;
      end
      // A dead transmitter still ends the byte so others are not blocked.
      if (byte_done) begin
        state <= S_IDLE;
        if (last_q) begin
          locked <= 1'b0;
          rr_ptr <= nxt(grant_id);
        end
      end
    end
  end

  a_ready_1hot: assert property (
    @(posedge clk) disable iff (!rst_n) $onehot0(req_ready));

  a_start_ready: assert property (
    @(posedge clk) disable iff (!rst_n)
    tx_start |-> (req_ready != '0));

endmodule
